phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Single-clock controller for the CPU's three-phase machine cycle X (fetch/decode), Y (memory access), Z (writeback).
- Generates one-cycle phase commit enables and the 2-bit phase code.
- Adds run/halt/single-step control and memory wait-state stalling in Y, with a wait timeout.
- Sits between the debug/control front panel, the memory interface and the CPU datapath.

Parameters:
- RUN_ON_RESET, 0, 1 = leave reset in X and run; 0 = leave reset in HALT.
- WAIT_W, 8, width of the wait-state counter.
- WAIT_MAX, 255, maximum consecutive stalled Y cycles before bus error; 0 disables the timeout.
- CNT_W, 16, width of the performance counters.

Ports:
- i_CLOCK  in  1  system clock; all logic on the rising edge.
- i_RESET  in  1  asynchronous, active-high reset.
- i_RUN  in  1  level; run continuously while high.
- i_STEP  in  1  rising edge requests one instruction while halted.
- i_HALT_REQ  in  1  level; halt at the next instruction boundary.
- i_MEM_WAIT  in  1  memory not ready; stalls Y.
- o_PHASE_X  out  1  X commit enable.
- o_PHASE_Y  out  1  Y commit enable.
- o_PHASE_Z  out  1  Z commit enable.
- o_STATE  out  2  0=HALT, 1=X, 2=Y, 3=Z.
- o_INSTR_DONE  out  1  pulse, equal to o_PHASE_Z.
- o_HALTED  out  1  high in HALT.
- o_BUS_ERROR  out  1  sticky wait-timeout flag.
- o_INSTR_COUNT  out  CNT_W  committed instructions.
- o_STALL_COUNT  out  CNT_W  stalled Y cycles.

Behaviour:
- Clock and reset: one clock, i_CLOCK; i_RESET is asynchronous and active-high. No negedge logic.
- Reset values:
  - State = X if RUN_ON_RESET, else HALT.
  - Wait counter = 0; step-edge register = 0.
  - o_BUS_ERROR = 0; both counters = 0.
  - Phase enables and o_INSTR_DONE = 0 (combinational from state).
- State register encodes o_STATE directly.
- Transitions:
  - HALT -> X when o_BUS_ERROR = 0 and (i_RUN = 1 or a step edge is seen). A step edge arms an internal one-shot flag.
  - X -> Y unconditionally after 1 cycle.
  - Y -> Z when i_MEM_WAIT = 0. While i_MEM_WAIT = 1, stay in Y and increment the wait counter.
  - Y -> HALT with o_BUS_ERROR <= 1 when i_MEM_WAIT = 1 and wait counter == WAIT_MAX (WAIT_MAX != 0). No Y or Z commit occurs.
  - Z -> X if i_RUN = 1, i_HALT_REQ = 0 and the one-shot flag is clear. Otherwise Z -> HALT, and the one-shot flag clears.
- Wait counter clears on every entry to Y.
- Phase enables (combinational):
  - o_PHASE_X = (state == X).
  - o_PHASE_Y = (state == Y) & ~i_MEM_WAIT.
  - o_PHASE_Z = (state == Z).
- Latency: 3 cycles per instruction with no waits, plus 1 per stall cycle. First X occurs 1 cycle after the run/step condition is sampled in HALT.
- i_STEP edge detect:
  - Registered previous value; edge = i_STEP & ~prev.
  - Edges outside HALT are ignored.
  - Step while i_RUN = 1: runs normally; the one-shot is cleared at Z.
- i_RUN or i_HALT_REQ changing mid-instruction: the current instruction always completes; both are sampled only in HALT and at Z.
- i_HALT_REQ and step edge in HALT on the same cycle: HALT_REQ has priority; no instruction executes.
- o_BUS_ERROR is sticky until reset. While it is set, stay in HALT and ignore RUN and STEP.
- Counters:
  - o_INSTR_COUNT increments on o_PHASE_Z.
  - o_STALL_COUNT increments each cycle in Y with i_MEM_WAIT = 1.
  - Both wrap modulo 2^CNT_W.
- Reset asserted mid-instruction: immediate return to reset state; no commit enable is asserted while reset is high.

Optional Feature:
- Macro: PHASE_SEQ_PERF_COUNT_EN.
- Defined: o_INSTR_COUNT and o_STALL_COUNT are implemented as described.
- Undefined: no counter registers are built; both outputs are constant 0.
- All other behaviour is identical in both cases.

Test Plan:
- Reset with RUN_ON_RESET=0, i_RUN=0 for 10 cycles -> o_STATE=0, o_HALTED=1, no phase enables.
- i_RUN=1 with no waits, 4 instructions -> o_STATE sequence 1,2,3 repeating; o_INSTR_DONE every 3rd cycle; o_INSTR_COUNT=4.
- i_MEM_WAIT=1 for 5 cycles in Y -> Y held 6 cycles, o_PHASE_Y only on the 6th; o_STALL_COUNT=5; instruction takes 8 cycles.
- In HALT, pulse i_STEP high for 4 cycles -> exactly one X,Y,Z, then o_STATE=0; a second pulse executes one more (count=2).
- Assert i_HALT_REQ during X with i_RUN=1 -> X,Y,Z complete, then HALT; o_INSTR_COUNT +1.
- WAIT_MAX=3, i_MEM_WAIT stuck at 1 -> HALT with o_BUS_ERROR=1 after 4 Y cycles, no o_PHASE_Y. RUN and STEP then ignored; i_RESET clears o_BUS_ERROR.

Source files
------------

// File: rtl/phase_sequencer.sv
// phase_sequencer: run/halt/single-step controller for the three-phase machine
// cycle X (fetch/decode), Y (memory access), Z (writeback).
//
// Optional build macro PHASE_SEQ_PERF_COUNT_EN: when defined, the instruction
// and stall performance counters are built; otherwise both count outputs are
// tied to zero and no counter registers exist.
//
// A level i_HALT_REQ also holds the sequencer in HALT (it blocks both i_RUN and
// a step edge), so a pending halt request never lets a new instruction start.

module phase_sequencer #(
  parameter int unsigned RUN_ON_RESET = 0,
  parameter int unsigned WAIT_W       = 8,
  parameter int unsigned WAIT_MAX     = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_CLOCK,
  input  logic             i_RESET,
  input  logic             i_RUN,
  input  logic             i_STEP,
  input  logic             i_HALT_REQ,
  input  logic             i_MEM_WAIT,
  output logic             o_PHASE_X,
  output logic             o_PHASE_Y,
  output logic             o_PHASE_Z,
  output logic [1:0]       o_STATE,
  output logic             o_INSTR_DONE,
  output logic             o_HALTED,
  output logic             o_BUS_ERROR,
  output logic [CNT_W-1:0] o_INSTR_COUNT,
  output logic [CNT_W-1:0] o_STALL_COUNT
);

  // Encoding equals the externally visible phase code.
  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StX    = 2'd1,
    StY    = 2'd2,
    StZ    = 2'd3
  } state_e;

  localparam state_e             ResetState = (RUN_ON_RESET != 0) ? StX : StHalt;
  localparam logic [WAIT_W-1:0]  WaitLimit  = WAIT_W'(WAIT_MAX);
  localparam bit                 TimeoutEn  = (WAIT_MAX != 0);

  state_e            state_q;
  logic              step_prev_q;
  logic              one_shot_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              bus_error_q;

  logic step_edge;
  logic wait_timeout;
  logic start_ok;
  logic continue_ok;

  // Step edge detection and the decision terms used by the state machine.
  always_comb begin
    step_edge    = i_STEP & ~step_prev_q;
    wait_timeout = TimeoutEn & i_MEM_WAIT & (wait_cnt_q == WaitLimit);
    start_ok     = ~bus_error_q & ~i_HALT_REQ & (i_RUN | step_edge);
    continue_ok  = i_RUN & ~i_HALT_REQ & ~one_shot_q;
  end

  // Phase state machine with wait counter, one-shot step flag and sticky bus error.
  always_ff @(posedge i_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q     <= ResetState;
      step_prev_q <= 1'b0;
      one_shot_q  <= 1'b0;
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      step_prev_q <= i_STEP;
      unique case (state_q)
        StHalt: begin
          if (start_ok) begin
            state_q <= StX;
            // A step edge limits execution to this one instruction.
            if (step_edge) begin
              one_shot_q <= 1'b1;
            end
          end
        end
        StX: begin
          state_q    <= StY;
          wait_cnt_q <= '0;
        end
        StY: begin
          if (!i_MEM_WAIT) begin
            state_q <= StZ;
          end else if (wait_timeout) begin
            // Abort without a Y or Z commit; only reset recovers.
            state_q     <= StHalt;
            bus_error_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StZ: begin
          if (continue_ok) begin
            state_q <= StX;
          end else begin
            state_q    <= StHalt;
            one_shot_q <= 1'b0;
          end
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  // Commit enables are masked while reset is held so nothing commits during reset.
  always_comb begin
    o_PHASE_X    = (state_q == StX) & ~i_RESET;
    o_PHASE_Y    = (state_q == StY) & ~i_MEM_WAIT & ~i_RESET;
    o_PHASE_Z    = (state_q == StZ) & ~i_RESET;
    o_INSTR_DONE = o_PHASE_Z;
    o_STATE      = state_q;
    o_HALTED     = (state_q == StHalt);
    o_BUS_ERROR  = bus_error_q;
  end

`ifdef PHASE_SEQ_PERF_COUNT_EN
  logic [CNT_W-1:0] instr_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Free-running wrap-around counters for committed instructions and Y stalls.
  always_ff @(posedge i_CLOCK or posedge i_RESET) begin
    if (i_RESET) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == StZ) begin
        instr_cnt_q <= instr_cnt_q + 1'b1;
      end
      if ((state_q == StY) && i_MEM_WAIT) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign o_INSTR_COUNT = instr_cnt_q;
  assign o_STALL_COUNT = stall_cnt_q;
`else
  assign o_INSTR_COUNT = '0;
  assign o_STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus a randomized
// run, all compared against a cycle-level behavioural model of the sequencer.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst, run, step, halt_req, mem_wait;
  logic rst_w, run_w, step_w, mw_w;
  logic zero = 1'b0;

  logic [1:0]  state, w_state, r_state;
  logic        px, py, pz, done, halted, berr;
  logic        w_px, w_py, w_pz, w_done, w_halted, w_berr;
  logic        r_px, r_py, r_pz, r_done, r_halted, r_berr;
  logic [15:0] ic, sc, w_ic, w_sc, r_ic, r_sc;
  logic [7:0]  dut_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.RUN_ON_RESET(0), .WAIT_W(8), .WAIT_MAX(255), .CNT_W(16)) dut (
    .i_CLOCK(clk), .i_RESET(rst), .i_RUN(run), .i_STEP(step), .i_HALT_REQ(halt_req),
    .i_MEM_WAIT(mem_wait), .o_PHASE_X(px), .o_PHASE_Y(py), .o_PHASE_Z(pz), .o_STATE(state),
    .o_INSTR_DONE(done), .o_HALTED(halted), .o_BUS_ERROR(berr), .o_INSTR_COUNT(ic),
    .o_STALL_COUNT(sc)
  );

  phase_sequencer #(.RUN_ON_RESET(0), .WAIT_W(8), .WAIT_MAX(3), .CNT_W(16)) dut_w (
    .i_CLOCK(clk), .i_RESET(rst_w), .i_RUN(run_w), .i_STEP(step_w), .i_HALT_REQ(zero),
    .i_MEM_WAIT(mw_w), .o_PHASE_X(w_px), .o_PHASE_Y(w_py), .o_PHASE_Z(w_pz),
    .o_STATE(w_state), .o_INSTR_DONE(w_done), .o_HALTED(w_halted), .o_BUS_ERROR(w_berr),
    .o_INSTR_COUNT(w_ic), .o_STALL_COUNT(w_sc)
  );

  phase_sequencer #(.RUN_ON_RESET(1), .WAIT_W(8), .WAIT_MAX(255), .CNT_W(16)) dut_r (
    .i_CLOCK(clk), .i_RESET(rst), .i_RUN(zero), .i_STEP(zero), .i_HALT_REQ(zero),
    .i_MEM_WAIT(zero), .o_PHASE_X(r_px), .o_PHASE_Y(r_py), .o_PHASE_Z(r_pz),
    .o_STATE(r_state), .o_INSTR_DONE(r_done), .o_HALTED(r_halted), .o_BUS_ERROR(r_berr),
    .o_INSTR_COUNT(r_ic), .o_STALL_COUNT(r_sc)
  );

  assign dut_vec = {state, px, py, pz, done, halted, berr};

  // Behavioural model of the main instance: phase number 0=HALT,1=X,2=Y,3=Z.
  logic [1:0]  m_state;
  logic        m_prev, m_os, m_berr;
  int          m_wait;
  logic [15:0] m_ic, m_sc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 2'd0; m_prev <= 1'b0; m_os <= 1'b0; m_berr <= 1'b0;
      m_wait <= 0; m_ic <= 16'd0; m_sc <= 16'd0;
    end else begin
      m_prev <= step;
      if (m_state == 2'd0) begin
        if (!m_berr && !halt_req && (run || (step && !m_prev))) begin
          m_state <= 2'd1;
          if (step && !m_prev) m_os <= 1'b1;
        end
      end else if (m_state == 2'd1) begin
        m_state <= 2'd2;
        m_wait  <= 0;
      end else if (m_state == 2'd2) begin
        if (!mem_wait) m_state <= 2'd3;
        else begin
          m_sc <= m_sc + 16'd1;
          if (m_wait == 255) begin
            m_state <= 2'd0;
            m_berr  <= 1'b1;
          end else m_wait <= m_wait + 1;
        end
      end else begin
        m_ic <= m_ic + 16'd1;
        if (run && !halt_req && !m_os) m_state <= 2'd1;
        else begin
          m_state <= 2'd0;
          m_os    <= 1'b0;
        end
      end
    end
  end

  function automatic logic [7:0] exp_vec();
    logic ex, ey, ez;
    ex = (m_state == 2'd1) && !rst;
    ey = (m_state == 2'd2) && !mem_wait && !rst;
    ez = (m_state == 2'd3) && !rst;
    return {m_state, ex, ey, ez, ez, (m_state == 2'd0), m_berr};
  endfunction

  function automatic logic [15:0] exp_cnt(input logic [15:0] v);
`ifdef PHASE_SEQ_PERF_COUNT_EN
    return v;
`else
    return v & 16'd0;
`endif
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_w = 1'b1;
    run = 1'b0; step = 1'b0; halt_req = 1'b0; mem_wait = 1'b0;
    run_w = 1'b0; step_w = 1'b0; mw_w = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({r_state, r_px} !== {2'd1, 1'b0}) begin
        errors++;
        $display("FAIL reset_gate: got state=%0d x=%b want state=1 x=0", r_state, r_px);
      end
    end
    next_cycle();
    rst = 1'b0; rst_w = 1'b0;
    @(negedge clk);
    checks++;
    if ({r_state, r_px} !== {2'd1, 1'b1}) begin
      errors++;
      $display("FAIL run_on_reset: got state=%0d x=%b want state=1 x=1", r_state, r_px);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 8'b00_000_0_1_0 || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL reset_halt cyc %0d: got %b want %b", i, dut_vec, 8'b00000010);
      end
    end
    checks++;
    if ({ic, sc} !== 32'd0) begin
      errors++;
      $display("FAIL reset_counts: got ic=%0d sc=%0d want 0 0", ic, sc);
    end
    next_cycle();
  endtask

  task automatic test_run();
    logic [15:0] ic0;
    int ndone;
    ic0 = m_ic; ndone = 0;
    run = 1'b1; mem_wait = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL run_start: got state=%0d want 0", state);
    end
    next_cycle();
    for (int i = 0; i < 12; i++) begin
      if (i == 11) run = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== 2'((i % 3) + 1) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL run_seq cyc %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (done) ndone++;
      checks++;
      if (done !== ((i % 3) == 2)) begin
        errors++;
        $display("FAIL run_done cyc %0d: got %b want %b", i, done, ((i % 3) == 2));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || ndone != 4 || ic !== exp_cnt(ic0 + 16'd4)) begin
      errors++;
      $display("FAIL run_end: got state=%0d done=%0d ic=%0d want 0 4 %0d", state, ndone, ic,
               exp_cnt(ic0 + 16'd4));
    end
    next_cycle();
  endtask

  task automatic test_wait();
    logic [15:0] sc0;
    int cyc;
    sc0 = m_sc; cyc = 0;
    run = 1'b1;
    next_cycle();
    run = 1'b0;
    @(negedge clk);
    cyc++;
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL wait_x: got state=%0d want 1", state);
    end
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      mem_wait = (k < 5);
      @(negedge clk);
      cyc++;
      checks++;
      if (state !== 2'd2 || py !== (k == 5) || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL wait_y k=%0d: got state=%0d y=%b want 2 %b", k, state, py, (k == 5));
      end
      next_cycle();
    end
    mem_wait = 1'b0;
    @(negedge clk);
    cyc++;
    checks++;
    if (state !== 2'd3 || cyc != 8 || sc !== exp_cnt(sc0 + 16'd5)) begin
      errors++;
      $display("FAIL wait_z: got state=%0d cyc=%0d sc=%0d want 3 8 %0d", state, cyc, sc,
               exp_cnt(sc0 + 16'd5));
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_step();
    logic [15:0] ic0;
    int nx, ny, nz;
    ic0 = m_ic;
    run = 1'b0;
    for (int p = 0; p < 2; p++) begin
      nx = 0; ny = 0; nz = 0;
      for (int c = 0; c < 10; c++) begin
        step = (c < 4);
        @(negedge clk);
        if (px) nx++;
        if (state == 2'd2) ny++;
        if (pz) nz++;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("FAIL step_seq p=%0d c=%0d: got %b want %b", p, c, dut_vec, exp_vec());
        end
        next_cycle();
      end
      checks++;
      if (nx != 1 || ny != 1 || nz != 1 || state !== 2'd0) begin
        errors++;
        $display("FAIL step_once p=%0d: got x=%0d y=%0d z=%0d st=%0d want 1 1 1 0", p, nx, ny,
                 nz, state);
      end
    end
    checks++;
    if (ic !== exp_cnt(ic0 + 16'd2)) begin
      errors++;
      $display("FAIL step_count: got %0d want %0d", ic, exp_cnt(ic0 + 16'd2));
    end
  endtask

  task automatic test_halt_req();
    logic [15:0] ic0;
    logic [1:0] seq [4];
    ic0 = m_ic;
    seq = '{2'd2, 2'd3, 2'd0, 2'd0};
    run = 1'b1;
    next_cycle();
    halt_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (state !== seq[k] || dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL halt_req k=%0d: got state=%0d want %0d", k, state, seq[k]);
      end
    end
    checks++;
    if (ic !== exp_cnt(ic0 + 16'd1)) begin
      errors++;
      $display("FAIL halt_req_count: got %0d want %0d", ic, exp_cnt(ic0 + 16'd1));
    end
    halt_req = 1'b0; run = 1'b0;
    next_cycle();
  endtask

  task automatic test_bus_error();
    logic [1:0] seq [7];
    seq = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    run_w = 1'b1; mw_w = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (w_state !== seq[c] || w_py !== 1'b0 || w_pz !== 1'b0 || w_berr !== (c == 6)) begin
        errors++;
        $display("FAIL buserr_seq c=%0d: got st=%0d y=%b e=%b want %0d 0 %b", c, w_state,
                 w_py, w_berr, seq[c], (c == 6));
      end
      next_cycle();
    end
    for (int c = 0; c < 6; c++) begin
      step_w = c[0];
      @(negedge clk);
      checks++;
      if (w_state !== 2'd0 || w_berr !== 1'b1 || w_halted !== 1'b1) begin
        errors++;
        $display("FAIL buserr_sticky c=%0d: got st=%0d e=%b want 0 1", c, w_state, w_berr);
      end
      next_cycle();
    end
    rst_w = 1'b1;
    run_w = 1'b0; step_w = 1'b0; mw_w = 1'b0;
    #1;
    checks++;
    if (w_berr !== 1'b0 || w_state !== 2'd0) begin
      errors++;
      $display("FAIL buserr_reset: got e=%b st=%0d want 0 0", w_berr, w_state);
    end
    next_cycle();
    rst_w = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run      = ($urandom_range(0, 99) < 70);
      halt_req = ($urandom_range(0, 99) < 10);
      mem_wait = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 3) == 0) step = ~step;
      rst = (i == 200 || i == 201);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec() || ic !== exp_cnt(m_ic) || sc !== exp_cnt(m_sc)) begin
        errors++;
        $display("FAIL random cyc %0d: got %b ic=%0d sc=%0d want %b ic=%0d sc=%0d", i,
                 dut_vec, ic, sc, exp_vec(), exp_cnt(m_ic), exp_cnt(m_sc));
      end
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    test_reset();
    test_run();
    test_wait();
    test_step();
    test_halt_req();
    test_bus_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
